// File: rtl/cfg_stream_loader_if.sv
// cfg_stream_loader_if: bit-serial configuration stream in, config-RAM write
// port and frame status out. The loader binds to the slave modport.
interface cfg_stream_loader_if #(
  parameter int WORD_W = 16,
  parameter int ADDR_W = 8
);
  logic              data_in;
  logic              data_valid;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WORD_W-1:0] wr_data;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output data_in, data_valid,
    input  wr_en, wr_addr, wr_data, busy, done, err
  );

  modport slave (
    input  data_in, data_valid,
    output wr_en, wr_addr, wr_data, busy, done, err
  );
endinterface

// File: rtl/cfg_stream_loader.sv
// cfg_stream_loader: hunts for SYNC, reads an ADDR_W-bit word count, then writes
// MSB-first words to config RAM. Optional even parity per word: CFG_LOADER_PARITY_EN.
module cfg_stream_loader #(
  parameter int         WORD_W = 16,
  parameter int         ADDR_W = 8,
  parameter logic [7:0] SYNC   = 8'hA5
) (
  input logic                clk,
  input logic                rst,
  cfg_stream_loader_if.slave bus
);
  localparam int BC_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int HC_W = (ADDR_W > 1) ? $clog2(ADDR_W) : 1;
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WORD_W - 1);
  localparam logic [HC_W-1:0] LAST_HDR = HC_W'(ADDR_W - 1);

  typedef enum logic [2:0] {
    HUNT,
    COUNT,
    DATA,
`ifdef CFG_LOADER_PARITY_EN
    PAR,
`endif
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        sreg_q, sreg_d;
  logic [HC_W-1:0]   hdr_cnt_q, hdr_cnt_d;
  logic [ADDR_W-1:0] n_q, n_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [WORD_W-1:0] wr_data_q, wr_data_d;
  logic              done_q, done_d;
`ifdef CFG_LOADER_PARITY_EN
  logic              err_q, err_d;
`endif

  logic [7:0]        sreg_shift;
  logic [ADDR_W-1:0] n_shift;
  logic [WORD_W-1:0] word_shift;
  logic              commit;
  logic              busy_w;

  always_comb begin
    state_d    = state_q;
    sreg_d     = sreg_q;
    hdr_cnt_d  = hdr_cnt_q;
    n_d        = n_q;
    bit_cnt_d  = bit_cnt_q;
    word_d     = word_q;
    addr_d     = addr_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    done_d     = 1'b0;
`ifdef CFG_LOADER_PARITY_EN
    err_d      = err_q;
`endif
    commit     = 1'b0;
    sreg_shift = 8'({sreg_q, bus.data_in});
    n_shift    = ADDR_W'({n_q, bus.data_in});
    word_shift = WORD_W'({word_q, bus.data_in});

    case (state_q)
      HUNT: begin
        if (bus.data_valid) begin
          if (sreg_shift == SYNC) begin
            state_d   = COUNT;
            sreg_d    = '0;
            hdr_cnt_d = '0;
`ifdef CFG_LOADER_PARITY_EN
            err_d     = 1'b0;
`endif
          end else begin
            sreg_d = sreg_shift;
          end
        end
      end
      COUNT: begin
        if (bus.data_valid) begin
          n_d       = n_shift;
          hdr_cnt_d = hdr_cnt_q + HC_W'(1);
          if (hdr_cnt_q == LAST_HDR) begin
            // An empty frame reports completion immediately on entering DONE.
            if (n_shift == '0) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              state_d   = DATA;
              addr_d    = '0;
              bit_cnt_d = '0;
            end
          end
        end
      end
      DATA: begin
        if (bus.data_valid) begin
          word_d    = word_shift;
          bit_cnt_d = bit_cnt_q + BC_W'(1);
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
`ifdef CFG_LOADER_PARITY_EN
            state_d   = PAR;
`else
            commit    = 1'b1;
`endif
          end
        end
      end
`ifdef CFG_LOADER_PARITY_EN
      PAR: begin
        if (bus.data_valid) begin
          if (^{word_q, bus.data_in}) begin
            err_d   = 1'b1;
            state_d = HUNT;
            sreg_d  = '0;
          end else begin
            commit = 1'b1;
          end
        end
      end
`endif
      DONE: begin
        // Stay until the pulse has been shown once, so done is high while in DONE.
        if (done_q) begin
          state_d = HUNT;
          sreg_d  = '0;
        end else begin
          done_d = 1'b1;
        end
      end
      default: begin
        state_d = HUNT;
        sreg_d  = '0;
      end
    endcase

    if (commit) begin
      wr_en_d   = 1'b1;
      wr_data_d = word_d;
      wr_addr_d = addr_q;
      addr_d    = addr_q + ADDR_W'(1);
      state_d   = (addr_q == n_q - ADDR_W'(1)) ? DONE : DATA;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= HUNT;
      sreg_q    <= '0;
      hdr_cnt_q <= '0;
      n_q       <= '0;
      bit_cnt_q <= '0;
      word_q    <= '0;
      addr_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
`ifdef CFG_LOADER_PARITY_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      hdr_cnt_q <= hdr_cnt_d;
      n_q       <= n_d;
      bit_cnt_q <= bit_cnt_d;
      word_q    <= word_d;
      addr_q    <= addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
`ifdef CFG_LOADER_PARITY_EN
      err_q     <= err_d;
`endif
    end
  end

  always_comb begin
    busy_w = (state_q == COUNT) || (state_q == DATA);
`ifdef CFG_LOADER_PARITY_EN
    busy_w = busy_w || (state_q == PAR);
`endif
  end

  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.busy    = busy_w;
  assign bus.done    = done_q;
`ifdef CFG_LOADER_PARITY_EN
  assign bus.err     = err_q;
`else
  assign bus.err     = 1'b0;
`endif
endmodule

// File: tb/tb_cfg_stream_loader.sv
// tb_cfg_stream_loader: directed frames plus randomized frame streams, checked
// against a frame-parsing reference model. Parity build: CFG_LOADER_PARITY_EN.
module tb_cfg_stream_loader;
  localparam int WORD_W = 16;
  localparam int ADDR_W = 8;
  localparam logic [7:0] SYNC_B = 8'hA5;
`ifdef CFG_LOADER_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  typedef struct { int addr; int data; int cyc; } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;

  cfg_stream_loader_if #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) bus ();

  cfg_stream_loader #(.WORD_W(WORD_W), .ADDR_W(ADDR_W), .SYNC(SYNC_B)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_bad    = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: one line per observed write / done pulse.
  wr_t mon_w;
  wr_t wr_q[$];
  int  done_q[$];
  int  done_busy_q[$];
  int  busy_cycles = 0;

  always @(negedge clk) begin
    if (rst) begin
      if (bus.busy) busy_cycles++;
      if (bus.wr_en) begin
        mon_w.addr = int'(bus.wr_addr);
        mon_w.data = int'(bus.wr_data);
        mon_w.cyc  = cyc;
        wr_q.push_back(mon_w);
        $display("wr   addr=%0d data=0x%04h cycle=%0d", bus.wr_addr, bus.wr_data, cyc);
      end
      if (bus.done) begin
        done_q.push_back(cyc);
        done_busy_q.push_back(int'(bus.busy));
        $display("done cycle=%0d", cyc);
      end
    end
  end

  // Stimulus: 0/1 are valid bits, 2 is a cycle with data_valid low.
  int stim[$];
  int fw[8];
  int mark_idx = -1;
  int t0 = 0;

  task automatic push_bits(input int val, input int width);
    for (int b = width - 1; b >= 0; b--) stim.push_back((val >> b) & 1);
  endtask

  task automatic add_frame(input int n, input bit bad_last);
    int p;
    push_bits(int'(SYNC_B), 8);
    push_bits(n, ADDR_W);
    for (int w = 0; w < n; w++) begin
      push_bits(fw[w], WORD_W);
      if (PB == 1) begin
        p = $countones(fw[w]) & 1;
        if (bad_last && w == n - 1) p = p ^ 1;
        stim.push_back(p);
      end
    end
    repeat (3) stim.push_back(2);
  endtask

  // Random noise that cannot complete a sync match before the real sync byte ends.
  task automatic add_noise(input int len);
    int q[$];
    logic [7:0] w;
    int hits;
    for (int tries = 0; tries < 50; tries++) begin
      q.delete();
      for (int i = 0; i < len; i++) q.push_back($urandom_range(0, 1));
      w = '0;
      hits = 0;
      foreach (q[i]) begin
        w = {w[6:0], 1'(q[i])};
        if (w == SYNC_B) hits++;
      end
      for (int b = 7; b >= 1; b--) begin
        w = {w[6:0], SYNC_B[b]};
        if (w == SYNC_B) hits++;
      end
      if (hits == 0) break;
      if (tries == 49) foreach (q[i]) q[i] = 0;
    end
    foreach (q[i]) stim.push_back(q[i]);
  endtask

  task automatic drive_stim();
    foreach (stim[k]) begin
      if (stim[k] == 2) begin
        bus.data_valid = 1'b0;
        bus.data_in    = 1'($urandom_range(0, 1));
      end else begin
        bus.data_valid = 1'b1;
        bus.data_in    = 1'(stim[k]);
      end
      @(posedge clk);
      #1;
      if (k == mark_idx) t0 = cyc;
    end
    bus.data_valid = 1'b0;
    bus.data_in    = 1'b0;
  endtask

  // Reference model: parse the valid-bit stream frame by frame.
  int exp_addr[$];
  int exp_data[$];
  int exp_done = 0;
  int exp_err  = 0;

  task automatic model_run();
    int bits[$];
    logic [7:0] win;
    int i, n, word, p;
    bit ok;
    exp_addr.delete();
    exp_data.delete();
    exp_done = 0;
    foreach (stim[k]) if (stim[k] != 2) bits.push_back(stim[k]);
    win = '0;
    i = 0;
    while (i < bits.size()) begin
      win = {win[6:0], 1'(bits[i])};
      i++;
      if (win == SYNC_B) begin
        win = '0;
        exp_err = 0;
        ok = 1'b1;
        if (i + ADDR_W > bits.size()) break;
        n = 0;
        repeat (ADDR_W) begin n = n * 2 + bits[i]; i++; end
        for (int w = 0; w < n; w++) begin
          if (i + WORD_W + PB > bits.size()) begin ok = 1'b0; break; end
          word = 0;
          repeat (WORD_W) begin word = word * 2 + bits[i]; i++; end
          if (PB == 1) begin
            p = bits[i];
            i++;
            if ((($countones(word) + p) % 2) != 0) begin
              exp_err = 1;
              ok = 1'b0;
              break;
            end
          end
          exp_addr.push_back(w);
          exp_data.push_back(word);
        end
        if (ok) exp_done++;
      end
    end
  endtask

  task automatic clear_mon();
    wr_q.delete();
    done_q.delete();
    done_busy_q.delete();
    busy_cycles = 0;
  endtask

  task automatic run_test(input string name);
    clear_mon();
    drive_stim();
    repeat (6) @(posedge clk);
    #1;
    model_run();
    check_eq({name, ":nwr"}, wr_q.size(), exp_addr.size());
    for (int k = 0; k < exp_addr.size() && k < wr_q.size(); k++) begin
      check_eq($sformatf("%s:addr%0d", name, k), wr_q[k].addr, exp_addr[k]);
      check_eq($sformatf("%s:data%0d", name, k), wr_q[k].data, exp_data[k]);
    end
    check_eq({name, ":ndone"}, done_q.size(), exp_done);
    check_eq({name, ":err"}, bus.err, exp_err);
    check_eq({name, ":busy_idle"}, bus.busy, 0);
  endtask

  // Two-word frame timing; d is the stall length inserted before the first write.
  task automatic check_frame_timing(input string name, input int d);
    int w0;
    w0 = t0 + 8 + ADDR_W + WORD_W + PB - 1 + d;
    if (wr_q.size() == 2 && done_q.size() == 1) begin
      check_eq({name, ":t_wr0"}, wr_q[0].cyc, w0);
      check_eq({name, ":t_wr1"}, wr_q[1].cyc, w0 + WORD_W + PB);
      check_eq({name, ":t_done"}, done_q[0], w0 + WORD_W + PB + 1);
      check_eq({name, ":busy_at_done"}, done_busy_q[0], 0);
    end else begin
      check_eq({name, ":shape"}, wr_q.size() * 10 + done_q.size(), 21);
    end
    check_eq({name, ":busy_cycles"}, busy_cycles, 8 + ADDR_W + 2 * (WORD_W + PB) - 8 + d);
  endtask

  task automatic check_reset_outputs(input string name);
    check_eq({name, ":wr_en"}, bus.wr_en, 0);
    check_eq({name, ":wr_addr"}, bus.wr_addr, 0);
    check_eq({name, ":wr_data"}, bus.wr_data, 0);
    check_eq({name, ":busy"}, bus.busy, 0);
    check_eq({name, ":done"}, bus.done, 0);
    check_eq({name, ":err"}, bus.err, 0);
  endtask

  initial begin
    bus.data_in    = 1'b0;
    bus.data_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Noise then a two-word frame, no stalls.
    stim.delete();
    push_bits(8'b1010_0100, 8);
    mark_idx = stim.size();
    fw[0] = 'h1234;
    fw[1] = 'hBEEF;
    add_frame(2, 1'b0);
    run_test("basic");
    if (wr_q.size() == 2) begin
      check_eq("basic:lit0", wr_q[0].data, 'h1234);
      check_eq("basic:lit1", wr_q[1].data, 'hBEEF);
    end
    check_frame_timing("basic", 0);

    // Same frame with a 3-cycle stall mid-header, then mid-word.
    for (int s = 0; s < 2; s++) begin
      stim.delete();
      push_bits(8'b1010_0100, 8);
      mark_idx = stim.size();
      add_frame(2, 1'b0);
      repeat (3) stim.insert(mark_idx + ((s == 0) ? 11 : 21), 2);
      run_test((s == 0) ? "stall_hdr" : "stall_word");
      check_frame_timing((s == 0) ? "stall_hdr" : "stall_word", 3);
    end

    // Empty frame.
    stim.delete();
    mark_idx = 0;
    add_frame(0, 1'b0);
    run_test("n0");
    if (done_q.size() == 1) check_eq("n0:t_done", done_q[0], t0 + 8 + ADDR_W - 1);
    check_eq("n0:busy_cycles", busy_cycles, ADDR_W);

`ifdef CFG_LOADER_PARITY_EN
    // Good parity on word 0, bad on word 1; then the next sync clears err.
    stim.delete();
    mark_idx = -1;
    fw[0] = 'h0001;
    fw[1] = 'h0003;
    add_frame(2, 1'b1);
    run_test("par_bad");
    check_eq("par_bad:err_lit", bus.err, 1);
    stim.delete();
    add_frame(0, 1'b0);
    run_test("par_clear");
`endif

    // Reset mid-word: partial frame discarded, then a clean frame from address 0.
    stim.delete();
    mark_idx = -1;
    push_bits(int'(SYNC_B), 8);
    push_bits(2, ADDR_W);
    push_bits(int'($urandom_range(0, 1023)), 10);
    clear_mon();
    drive_stim();
    rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_err = 0;
    check_eq("midrst:no_write", wr_q.size(), 0);
    stim.delete();
    fw[0] = int'($urandom_range(0, 65535));
    fw[1] = int'($urandom_range(0, 65535));
    add_frame(2, 1'b0);
    run_test("after_rst");

    // Sync pattern inside the payload must not resynchronize.
    stim.delete();
    fw[0] = 'hA5A5;
    fw[1] = 'h00A5;
    add_frame(2, 1'b0);
    run_test("payload_sync");
    if (wr_q.size() > 0) check_eq("payload_sync:lit0", wr_q[0].data, 'hA5A5);

    // Randomized streams: noise, frames of random length, random stalls.
    for (int it = 0; it < 25; it++) begin
      int nf, n;
      bit bad;
      stim.delete();
      nf = $urandom_range(1, 3);
      for (int f = 0; f < nf; f++) begin
        add_noise($urandom_range(0, 12));
        n = $urandom_range(0, 4);
        for (int w = 0; w < n; w++) fw[w] = int'($urandom_range(0, 65535));
        bad = (PB == 1) && (n > 0) && ($urandom_range(0, 3) == 0);
        add_frame(n, bad);
      end
      repeat ($urandom_range(0, 6)) stim.insert($urandom_range(0, stim.size() - 1), 2);
      run_test($sformatf("rand%0d", it));
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end
endmodule
